// File: rtl/mul_rs_dispatch_if.sv
// Issue, CDB, exec-dispatch and status signals between the issue stage, the RS and the mul/div unit.
// The master drives issue, CDB, flush and completion. The slave (the RS) drives dispatch and status.
interface mul_rs_dispatch_if #(
   parameter int DW   = 8,
   parameter int TAGW = 4
);
   logic            iss_valid;
   logic            iss_ready;
   logic [3:0]      iss_func;
   logic [TAGW-1:0] iss_rd;
   logic [2:0]      iss_rob;
   logic            iss_q1_rdy;
   logic [DW-1:0]   iss_v1;
   logic [TAGW-1:0] iss_q1;
   logic            iss_q2_rdy;
   logic [DW-1:0]   iss_v2;
   logic [TAGW-1:0] iss_q2;
   logic            cdb_valid;
   logic [TAGW-1:0] cdb_rd;
   logic [DW-1:0]   cdb_data;
   logic            flush;
   logic            ex_b;
   logic [2:0]      ex_rs_index;
   logic [DW-1:0]   ex_rs1_data;
   logic [DW-1:0]   ex_rs2_data;
   logic [3:0]      ex_func;
   logic [TAGW-1:0] ex_rd;
   logic [2:0]      ex_rob_ind;
   logic            ex_done;
   logic [2:0]      ex_done_idx;
   logic [1:0]      count;
   logic            err_func;

   modport master (
      output iss_valid, iss_func, iss_rd, iss_rob, iss_q1_rdy, iss_v1, iss_q1,
             iss_q2_rdy, iss_v2, iss_q2, cdb_valid, cdb_rd, cdb_data, flush,
             ex_done, ex_done_idx,
      input  iss_ready, ex_b, ex_rs_index, ex_rs1_data, ex_rs2_data, ex_func,
             ex_rd, ex_rob_ind, count, err_func
   );

   modport slave (
      input  iss_valid, iss_func, iss_rd, iss_rob, iss_q1_rdy, iss_v1, iss_q1,
             iss_q2_rdy, iss_v2, iss_q2, cdb_valid, cdb_rd, cdb_data, flush,
             ex_done, ex_done_idx,
      output iss_ready, ex_b, ex_rs_index, ex_rs1_data, ex_rs2_data, ex_func,
             ex_rd, ex_rob_ind, count, err_func
   );
endinterface

// File: rtl/mul_rs_dispatch.sv
// 3-entry mul/div reservation station: CDB wakeup, oldest-ready dispatch one cycle after operands are registered.
// Backpressure: iss_ready drops when all entries are busy or during flush. Only one exec op is in flight at a time.
module mul_rs_dispatch #(
   parameter int DEPTH = 3,
   parameter int DW    = 8,
   parameter int TAGW  = 4
) (
   input logic              clk2,
   input logic              rst_n,
   mul_rs_dispatch_if.slave rs
);
   logic [DEPTH-1:0] r_valid, r_disp, r_r1, r_r2;
   logic [3:0]       r_func [DEPTH];
   logic [TAGW-1:0]  r_rd   [DEPTH];
   logic [2:0]       r_rob  [DEPTH];
   logic [DW-1:0]    r_v1   [DEPTH];
   logic [DW-1:0]    r_v2   [DEPTH];
   logic [TAGW-1:0]  r_q1   [DEPTH];
   logic [TAGW-1:0]  r_q2   [DEPTH];
   logic [1:0]       r_age  [DEPTH];
   logic             r_exec_busy;
   logic             r_ex_b;
   logic [2:0]       r_ex_rs_index;
   logic [DW-1:0]    r_ex_rs1_data, r_ex_rs2_data;
   logic [3:0]       r_ex_func;
   logic [TAGW-1:0]  r_ex_rd;
   logic [2:0]       r_ex_rob_ind;
   logic             r_err_func;

   logic       w_free_vld, w_sel_vld, w_legal, w_issue, w_done_ok;
   logic [1:0] w_free_idx, w_sel_idx, w_sel_age, w_done_idx, w_count;

   always_comb begin
      w_free_vld = 1'b0;
      w_free_idx = 2'd0;
      w_count    = 2'd0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!r_valid[i]) begin
            w_free_vld = 1'b1;
            w_free_idx = 2'(i);
         end
         w_count = w_count + {1'b0, r_valid[i]};
      end
      // Strict '>' keeps the lowest index on equal ages.
      w_sel_vld = 1'b0;
      w_sel_idx = 2'd0;
      w_sel_age = 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && !r_disp[i] && r_r1[i] && r_r2[i] &&
             (!w_sel_vld || r_age[i] > w_sel_age)) begin
            w_sel_vld = 1'b1;
            w_sel_idx = 2'(i);
            w_sel_age = r_age[i];
         end
      end
      w_legal    = (rs.iss_func == 4'b0010) || (rs.iss_func == 4'b0011);
      w_issue    = rs.iss_valid && rs.iss_ready;
      w_done_idx = rs.ex_done_idx[1:0];
      w_done_ok  = rs.ex_done && r_exec_busy && (rs.ex_done_idx < 3'(DEPTH)) &&
                   r_valid[w_done_idx] && r_disp[w_done_idx];
   end

   always_ff @(posedge clk2) begin
      if (!rst_n) begin
         r_valid       <= '0;
         r_disp        <= '0;
         r_r1          <= '0;
         r_r2          <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_func[i] <= '0;
            r_rd[i]   <= '0;
            r_rob[i]  <= '0;
            r_v1[i]   <= '0;
            r_v2[i]   <= '0;
            r_q1[i]   <= '0;
            r_q2[i]   <= '0;
            r_age[i]  <= '0;
         end
         r_exec_busy   <= 1'b0;
         r_ex_b        <= 1'b0;
         r_ex_rs_index <= '0;
         r_ex_rs1_data <= '0;
         r_ex_rs2_data <= '0;
         r_ex_func     <= '0;
         r_ex_rd       <= '0;
         r_ex_rob_ind  <= '0;
         r_err_func    <= 1'b0;
      end else if (rs.flush) begin
         r_valid     <= '0;
         r_disp      <= '0;
         r_exec_busy <= 1'b0;
         r_ex_b      <= 1'b0;
      end else begin
         r_ex_b <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && rs.cdb_valid) begin
               if (!r_r1[i] && r_q1[i] == rs.cdb_rd) begin
                  r_v1[i] <= rs.cdb_data;
                  r_r1[i] <= 1'b1;
               end
               if (!r_r2[i] && r_q2[i] == rs.cdb_rd) begin
                  r_v2[i] <= rs.cdb_data;
                  r_r2[i] <= 1'b1;
               end
            end
         end
         if (w_done_ok) begin
            r_valid[w_done_idx] <= 1'b0;
            r_disp[w_done_idx]  <= 1'b0;
            r_exec_busy         <= 1'b0;
         end
         if (!r_exec_busy && w_sel_vld) begin
            r_ex_b             <= 1'b1;
            r_ex_rs_index      <= {1'b0, w_sel_idx};
            r_ex_rs1_data      <= r_v1[w_sel_idx];
            r_ex_rs2_data      <= r_v2[w_sel_idx];
            r_ex_func          <= r_func[w_sel_idx];
            r_ex_rd            <= r_rd[w_sel_idx];
            r_ex_rob_ind       <= r_rob[w_sel_idx];
            r_disp[w_sel_idx]  <= 1'b1;
            r_exec_busy        <= 1'b1;
         end
         if (w_issue && !w_legal) begin
            r_err_func <= 1'b1;
         end else if (w_issue) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (r_valid[i] && r_age[i] != 2'd3) r_age[i] <= r_age[i] + 2'd1;
            end
            // The allocated slot is invalid in registered state, so no wakeup/done write collides with it.
            r_valid[w_free_idx] <= 1'b1;
            r_disp[w_free_idx]  <= 1'b0;
            r_age[w_free_idx]   <= 2'd0;
            r_func[w_free_idx]  <= rs.iss_func;
            r_rd[w_free_idx]    <= rs.iss_rd;
            r_rob[w_free_idx]   <= rs.iss_rob;
            r_q1[w_free_idx]    <= rs.iss_q1;
            r_q2[w_free_idx]    <= rs.iss_q2;
            r_r1[w_free_idx]    <= rs.iss_q1_rdy || (rs.cdb_valid && rs.cdb_rd == rs.iss_q1);
            r_r2[w_free_idx]    <= rs.iss_q2_rdy || (rs.cdb_valid && rs.cdb_rd == rs.iss_q2);
            r_v1[w_free_idx]    <= rs.iss_q1_rdy ? rs.iss_v1 :
                                   (rs.cdb_valid && rs.cdb_rd == rs.iss_q1) ? rs.cdb_data : rs.iss_v1;
            r_v2[w_free_idx]    <= rs.iss_q2_rdy ? rs.iss_v2 :
                                   (rs.cdb_valid && rs.cdb_rd == rs.iss_q2) ? rs.cdb_data : rs.iss_v2;
         end
      end
   end

   assign rs.iss_ready   = w_free_vld && !rs.flush;
   assign rs.count       = w_count;
   assign rs.ex_b        = r_ex_b;
   assign rs.ex_rs_index = r_ex_rs_index;
   assign rs.ex_rs1_data = r_ex_rs1_data;
   assign rs.ex_rs2_data = r_ex_rs2_data;
   assign rs.ex_func     = r_ex_func;
   assign rs.ex_rd       = r_ex_rd;
   assign rs.ex_rob_ind  = r_ex_rob_ind;
   assign rs.err_func    = r_err_func;
endmodule

// File: tb/tb_mul_rs_dispatch.sv
// Directed bench for mul_rs_dispatch: issue, bypass, wakeup, oldest-first select, full, flush, illegal func, reset.
module tb_mul_rs_dispatch;
   logic clk2 = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk2 = ~clk2;

   mul_rs_dispatch_if #(.DW(8), .TAGW(4)) bus ();

   mul_rs_dispatch #(.DEPTH(3), .DW(8), .TAGW(4)) dut (
      .clk2  (clk2),
      .rst_n (rst_n),
      .rs    (bus.slave)
   );

   task automatic tick();
      @(posedge clk2);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.iss_valid   = 1'b0;
      bus.iss_func    = 4'b0000;
      bus.iss_rd      = 4'd0;
      bus.iss_rob     = 3'd0;
      bus.iss_q1_rdy  = 1'b0;
      bus.iss_v1      = 8'd0;
      bus.iss_q1      = 4'd0;
      bus.iss_q2_rdy  = 1'b0;
      bus.iss_v2      = 8'd0;
      bus.iss_q2      = 4'd0;
      bus.cdb_valid   = 1'b0;
      bus.cdb_rd      = 4'd0;
      bus.cdb_data    = 8'd0;
      bus.flush       = 1'b0;
      bus.ex_done     = 1'b0;
      bus.ex_done_idx = 3'd0;
   endtask

   task automatic issue(input logic [3:0] f, input logic [3:0] rd, input logic [2:0] rob,
                        input logic r1, input logic [7:0] v1, input logic [3:0] q1,
                        input logic r2, input logic [7:0] v2, input logic [3:0] q2);
      bus.iss_valid  = 1'b1;
      bus.iss_func   = f;
      bus.iss_rd     = rd;
      bus.iss_rob    = rob;
      bus.iss_q1_rdy = r1;
      bus.iss_v1     = v1;
      bus.iss_q1     = q1;
      bus.iss_q2_rdy = r2;
      bus.iss_v2     = v2;
      bus.iss_q2     = q2;
   endtask

   task automatic done(input logic [2:0] idx);
      bus.ex_done     = 1'b1;
      bus.ex_done_idx = idx;
      tick();
      bus.ex_done     = 1'b0;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_ex_b", 32'(bus.ex_b), 0);
      chk("rst_err", 32'(bus.err_func), 0);
      chk("rst_rs1", 32'(bus.ex_rs1_data), 0);
      rst_n = 1'b1;
      tick();
      chk("rst_iss_ready", 32'(bus.iss_ready), 1);

      // T1: ready MUL dispatches the cycle after issue
      issue(4'b0010, 4'd2, 3'd1, 1'b1, 8'd3, 4'd0, 1'b1, 8'd5, 4'd0);
      tick();
      idle();
      chk("t1_ex_b_early", 32'(bus.ex_b), 0);
      chk("t1_count", 32'(bus.count), 1);
      tick();
      chk("t1_ex_b", 32'(bus.ex_b), 1);
      chk("t1_func", 32'(bus.ex_func), 32'h2);
      chk("t1_rs1", 32'(bus.ex_rs1_data), 3);
      chk("t1_rs2", 32'(bus.ex_rs2_data), 5);
      chk("t1_idx", 32'(bus.ex_rs_index), 0);
      chk("t1_rd", 32'(bus.ex_rd), 2);
      chk("t1_rob", 32'(bus.ex_rob_ind), 1);
      tick();
      chk("t1_ex_b_pulse", 32'(bus.ex_b), 0);
      chk("t1_rs1_hold", 32'(bus.ex_rs1_data), 3);
      done(3'd0);
      chk("t1_freed", 32'(bus.count), 0);

      // T2: DIV waits on tag 4, woken by CDB two cycles later
      issue(4'b0011, 4'd5, 3'd2, 1'b1, 8'd20, 4'd0, 1'b0, 8'd0, 4'd4);
      tick();
      idle();
      tick();
      chk("t2_wait", 32'(bus.ex_b), 0);
      bus.cdb_valid = 1'b1;
      bus.cdb_rd    = 4'd4;
      bus.cdb_data  = 8'd7;
      tick();
      idle();
      chk("t2_wake_no_b", 32'(bus.ex_b), 0);
      tick();
      chk("t2_ex_b", 32'(bus.ex_b), 1);
      chk("t2_rs2", 32'(bus.ex_rs2_data), 7);
      chk("t2_rs1", 32'(bus.ex_rs1_data), 20);
      chk("t2_func", 32'(bus.ex_func), 32'h3);
      done(3'd0);

      // T3: A dispatches, B and C fill the RS; D is refused while full
      issue(4'b0010, 4'd1, 3'd0, 1'b1, 8'd1, 4'd0, 1'b1, 8'd1, 4'd0);
      tick();
      issue(4'b0010, 4'd2, 3'd1, 1'b1, 8'd2, 4'd0, 1'b1, 8'd2, 4'd0);
      tick();
      chk("t3_a_disp", 32'(bus.ex_b), 1);
      chk("t3_a_idx", 32'(bus.ex_rs_index), 0);
      issue(4'b0011, 4'd3, 3'd2, 1'b1, 8'd3, 4'd0, 1'b1, 8'd3, 4'd0);
      tick();
      issue(4'b0010, 4'd4, 3'd3, 1'b1, 8'd4, 4'd0, 1'b1, 8'd4, 4'd0);
      chk("t3_full_count", 32'(bus.count), 3);
      chk("t3_full_ready", 32'(bus.iss_ready), 0);
      tick();
      idle();
      chk("t3_full_hold", 32'(bus.count), 3);
      done(3'd2);
      chk("t3_bad_done_count", 32'(bus.count), 3);
      tick();
      chk("t3_bad_done_no_b", 32'(bus.ex_b), 0);
      done(3'd0);
      chk("t3_done_count", 32'(bus.count), 2);
      chk("t3_done_ready", 32'(bus.iss_ready), 1);
      chk("t3_done_no_b", 32'(bus.ex_b), 0);
      tick();
      chk("t3_b_disp", 32'(bus.ex_b), 1);
      chk("t3_b_idx", 32'(bus.ex_rs_index), 1);
      chk("t3_b_rd", 32'(bus.ex_rd), 2);
      done(3'd1);
      chk("t3_after_b", 32'(bus.count), 1);
      tick();
      chk("t3_c_disp", 32'(bus.ex_b), 1);
      chk("t3_c_idx", 32'(bus.ex_rs_index), 2);
      chk("t3_c_func", 32'(bus.ex_func), 32'h3);
      done(3'd2);
      chk("t3_empty", 32'(bus.count), 0);

      // T4: issue-cycle CDB bypass on src1
      issue(4'b0010, 4'd7, 3'd3, 1'b0, 8'd0, 4'd6, 1'b1, 8'd4, 4'd0);
      bus.cdb_valid = 1'b1;
      bus.cdb_rd    = 4'd6;
      bus.cdb_data  = 8'd9;
      tick();
      idle();
      tick();
      chk("t4_ex_b", 32'(bus.ex_b), 1);
      chk("t4_rs1", 32'(bus.ex_rs1_data), 9);
      chk("t4_rs2", 32'(bus.ex_rs2_data), 4);
      done(3'd0);

      // T5: flush with one op in flight and one waiting; stale done ignored
      issue(4'b0010, 4'd8, 3'd4, 1'b1, 8'd11, 4'd0, 1'b1, 8'd12, 4'd0);
      tick();
      issue(4'b0011, 4'd9, 3'd5, 1'b0, 8'd0, 4'd10, 1'b1, 8'd1, 4'd0);
      tick();
      idle();
      chk("t5_two", 32'(bus.count), 2);
      chk("t5_inflight", 32'(bus.ex_b), 1);
      bus.flush = 1'b1;
      #1;
      chk("t5_flush_ready", 32'(bus.iss_ready), 0);
      tick();
      bus.flush = 1'b0;
      chk("t5_flush_count", 32'(bus.count), 0);
      chk("t5_flush_b", 32'(bus.ex_b), 0);
      done(3'd0);
      chk("t5_stale_count", 32'(bus.count), 0);
      chk("t5_stale_b", 32'(bus.ex_b), 0);
      issue(4'b0010, 4'd1, 3'd6, 1'b1, 8'd21, 4'd0, 1'b1, 8'd22, 4'd0);
      tick();
      idle();
      tick();
      chk("t5_redispatch", 32'(bus.ex_b), 1);
      chk("t5_redispatch_rs1", 32'(bus.ex_rs1_data), 21);
      done(3'd0);

      // T6: illegal func, then reset while a dispatch is due
      issue(4'b0001, 4'd3, 3'd0, 1'b1, 8'd1, 4'd0, 1'b1, 8'd1, 4'd0);
      tick();
      idle();
      chk("t6_no_alloc", 32'(bus.count), 0);
      chk("t6_err", 32'(bus.err_func), 1);
      tick();
      chk("t6_err_sticky", 32'(bus.err_func), 1);
      issue(4'b0010, 4'd5, 3'd7, 1'b1, 8'd33, 4'd0, 1'b1, 8'd44, 4'd0);
      tick();
      idle();
      rst_n = 1'b0;
      tick();
      chk("t6_rst_b", 32'(bus.ex_b), 0);
      chk("t6_rst_count", 32'(bus.count), 0);
      chk("t6_rst_err", 32'(bus.err_func), 0);
      chk("t6_rst_rs1", 32'(bus.ex_rs1_data), 0);
      chk("t6_rst_rob", 32'(bus.ex_rob_ind), 0);
      rst_n = 1'b1;
      tick();
      chk("t6_ready", 32'(bus.iss_ready), 1);
      tick();
      chk("t6_no_ghost", 32'(bus.ex_b), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
